sram_responder: RTL
===================

# sram_responder

Clocked behavioural responder for the 16-bit asynchronous-SRAM pin interface: it plays the memory-chip end of the bus that the SRAM controller drives, so the controller can be exercised on-chip and in simulation without an external device. It samples the active-low chip-enable, output-enable, write-enable and byte-lane strobes on each clock edge. Writes are committed to an internal array with per-byte masking. Reads return data on the shared tristate bus after a fixed pipeline latency.

## Interface
- ADDR_WIDTH, 8, word-address width; array depth is 2**ADDR_WIDTH 16-bit words.
- READ_LATENCY, 1, clock edges from the sampled read request to the bus being driven; legal range 1–4.

- clk  input  1  single clock; all sampling on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- addr  input  ADDR_WIDTH  word address from the controller.
- bus  inout  16  shared data bus; written data in, read data out.
- chip_en  input  1  chip enable, active-low.
- output_enable  input  1  output enable, active-low.
- data_enable  input  1  write enable, active-low.
- UB  input  1  upper-byte strobe (bus[15:8]), active-low.
- LB  input  1  lower-byte strobe (bus[7:0]), active-low.
- wr_count  output  16  number of write cycles accepted; wraps modulo 2^16.
- rd_count  output  16  number of read requests accepted; wraps modulo 2^16.
- conflict  output  1  sticky flag: a write was sampled while output_enable was also low.

## Operation
- Sampled cycle classes (at rising clk, chip_en=0 required, else the cycle is IDLE):
  - WRITE: data_enable=0. For each lane whose strobe is 0, mem[addr][lane] <= bus[lane]; lanes with strobe=1 are unchanged. wr_count increments even if both strobes are 1. If output_enable=0 at the same edge, the write still wins and conflict is set.
  - READ: data_enable=1, output_enable=0. A request carrying {addr, UB, LB} enters the read pipeline; rd_count increments.
  - IDLE: anything else; the pipeline receives a bubble.
- Read pipeline: READ_LATENCY stages of {valid, addr, UB, LB}. At the final stage, the output register loads mem[addr] (the array value after all writes committed at earlier edges), plus the lane strobes and the valid bit.
- Bus drive, per lane: the lane is driven from the output register when all of the following hold:
  - the output register is valid;
  - its lane strobe is 0;
  - the live (unregistered) chip_en=0, output_enable=0 and data_enable=1.
  - Otherwise the lane is high-Z.
  - The live-pin gating is combinational, so the responder releases the bus in the same cycle the controller turns it around.
- Continuous read: holding a read for N cycles with a changing addr returns one word per cycle, each delayed by READ_LATENCY.
- Read-after-write to the same address: a read sampled on the edge after the write returns the new data.
- Memory array is not cleared by reset; contents are undefined until written.

## Timing
- Reset (rst_n=0, asynchronous) forces the following immediately, independent of clk:
  - pipeline and output-register valid bits cleared;
  - bus fully high-Z;
  - wr_count=0, rd_count=0, conflict=0.
- Reset mid-read: any in-flight reads are discarded; the bus is released immediately.
- First sampling edge after reset deasserts is the first rising clk with rst_n=1.
- Write latency: committed at the sampling edge; visible to a read sampled at the next edge.
- Read latency: request sampled at edge T; bus valid after edge T+READ_LATENCY, held until the next edge.
- Counters and conflict update at the same edge the cycle is sampled.
- conflict clears only on reset.
- Counter wrap: 16'hFFFF + 1 = 16'h0000, with no flag.

## Test plan
- Reset check: assert rst_n=0 mid-read with the bus being driven.
  - Required: bus=Z and counters=0 within the same cycle, without waiting for a clk edge.
- Full-word write and read: write 16'hA55A to addr 8'h10 (UB=LB=0), then read addr 8'h10.
  - Required: bus=16'hA55A exactly READ_LATENCY edges after the read is sampled; wr_count=1, rd_count=1.
- Byte-masked write: write 16'h1234 to addr 3 (full word), then write 16'hFFFF with UB=1, LB=0.
  - Required: a full read returns 16'h12FF.
  - Required: a read with UB=0, LB=1 drives only bus[15:8]=8'h12, with bus[7:0]=Z.
- Back-to-back reads: read addr 0,1,2,3 on consecutive cycles after writing 16'h0000–16'h0003 to them.
  - Required: bus shows 0,1,2,3 on consecutive cycles.
  - Required: raising output_enable mid-stream makes the bus Z in that same cycle.
- Write/OE conflict: chip_en=0, data_enable=0, output_enable=0, bus driven to 16'hBEEF at addr 5.
  - Required: mem[5]=16'hBEEF and conflict=1; conflict stays 1 through subsequent clean accesses.
- Counter wrap: issue 65536 write cycles with UB=LB=1.
  - Required: wr_count returns to 0 and the array is unchanged.

Source files
------------

// File: rtl/sram_responder_if.sv
// sram_responder_if
// Pin bundle of a 16-bit asynchronous-SRAM bus, seen from both ends.
//   addr           word address from the controller
//   chip_en        chip enable, active-low
//   output_enable  output enable, active-low
//   data_enable    write enable, active-low
//   UB / LB        upper / lower byte strobes, active-low
//   bus            shared 16-bit data bus (resolved here)
//   host_data/host_oe  controller-side drive of bus (whole word)
//   resp_data/resp_oe  memory-side drive of bus (per byte lane)
// The bus wire is resolved inside the interface so both ends stay simple
// single-driver logic. A correct controller never drives while the memory
// does; if it does, the controller's value is what appears on the wire.
interface sram_responder_if #(
  parameter int ADDR_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] addr;
  logic                  chip_en;
  logic                  output_enable;
  logic                  data_enable;
  logic                  UB;
  logic                  LB;
  logic [15:0]           host_data;
  logic                  host_oe;
  logic [15:0]           resp_data;
  logic [1:0]            resp_oe;
  wire  [15:0]           bus;

  assign bus[15:8] = host_oe    ? host_data[15:8] :
                     resp_oe[1] ? resp_data[15:8] : 8'hzz;
  assign bus[7:0]  = host_oe    ? host_data[7:0]  :
                     resp_oe[0] ? resp_data[7:0]  : 8'hzz;

  modport master (
    output addr, chip_en, output_enable, data_enable, UB, LB,
    output host_data, host_oe,
    input  bus
  );

  modport slave (
    input  addr, chip_en, output_enable, data_enable, UB, LB,
    input  bus,
    output resp_data, resp_oe
  );
endinterface

// File: rtl/sram_responder.sv
// sram_responder
// Behavioural memory-chip end of a 16-bit asynchronous-SRAM bus. Pins are
// sampled on each rising clk: writes commit to an internal array with
// per-byte masking, reads travel through a READ_LATENCY-deep pipeline and
// are driven back per byte lane, gated live by the controller's pins.
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   mem_bus   SRAM pin bundle (slave side)
//   wr_count  accepted write cycles, wraps modulo 2^16
//   rd_count  accepted read requests, wraps modulo 2^16
//   conflict  sticky: a write was sampled while output_enable was low
// Parameters:
//   ADDR_WIDTH    word-address width (depth 2**ADDR_WIDTH)
//   READ_LATENCY  edges from sampled read to bus valid, legal 1..4
module sram_responder #(
  parameter int ADDR_WIDTH   = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  sram_responder_if.slave        mem_bus,
  output logic [15:0]            wr_count,
  output logic [15:0]            rd_count,
  output logic                   conflict
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  // Storage has no reset so it maps onto block RAM.
  logic [15:0] mem [DEPTH];

  logic is_write;
  logic is_read;
  logic live_read;

  logic                  pipe_valid [READ_LATENCY];
  logic [ADDR_WIDTH-1:0] pipe_addr  [READ_LATENCY];
  logic [1:0]            pipe_strb  [READ_LATENCY];   // {UB, LB}

  logic        out_valid_reg;
  logic [15:0] out_data_reg;
  logic [1:0]  out_strb_reg;

  // A write wins over a simultaneous output enable.
  assign is_write = ~mem_bus.chip_en & ~mem_bus.data_enable;
  assign is_read  = ~mem_bus.chip_en &  mem_bus.data_enable & ~mem_bus.output_enable;
  // Same condition, used unregistered to release the bus the moment the
  // controller turns it around.
  assign live_read = is_read;

  // Array write with byte-lane masking.
  always_ff @(posedge clk) begin
    if (rst_n && is_write) begin
      if (!mem_bus.LB) mem[mem_bus.addr][7:0]  <= mem_bus.bus[7:0];
      if (!mem_bus.UB) mem[mem_bus.addr][15:8] <= mem_bus.bus[15:8];
    end
  end

  // Read pipeline valid bits and output-register valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < READ_LATENCY; i++) pipe_valid[i] <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      pipe_valid[0] <= is_read;
      for (int i = 1; i < READ_LATENCY; i++) pipe_valid[i] <= pipe_valid[i-1];
      out_valid_reg <= pipe_valid[READ_LATENCY-1];
    end
  end

  // Request payload and registered array read; only meaningful where the
  // matching valid bit is set, so no reset is needed.
  always_ff @(posedge clk) begin
    pipe_addr[0] <= mem_bus.addr;
    pipe_strb[0] <= {mem_bus.UB, mem_bus.LB};
    for (int i = 1; i < READ_LATENCY; i++) begin
      pipe_addr[i] <= pipe_addr[i-1];
      pipe_strb[i] <= pipe_strb[i-1];
    end
    // Non-blocking read sees the array before this edge's write, i.e. every
    // write committed at an earlier edge.
    out_data_reg <= mem[pipe_addr[READ_LATENCY-1]];
    out_strb_reg <= pipe_strb[READ_LATENCY-1];
  end

  // Counters and sticky conflict flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_count <= 16'h0000;
      rd_count <= 16'h0000;
      conflict <= 1'b0;
    end else begin
      if (is_write) wr_count <= wr_count + 16'h0001;
      if (is_read)  rd_count <= rd_count + 16'h0001;
      if (is_write && !mem_bus.output_enable) conflict <= 1'b1;
    end
  end

  // Per-lane bus drive: lane 1 is bus[15:8] (UB), lane 0 is bus[7:0] (LB).
  assign mem_bus.resp_data = out_data_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
      assign mem_bus.resp_oe[gi] = out_valid_reg & ~out_strb_reg[gi] & live_read;
    end
  endgenerate
endmodule
